// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shifter controller.
// Drives an external single-step shifter one position per clock.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             la_in,
  input  logic             lr_in,
  output logic [WIDTH-1:0] sh_a,
  output logic             sh_la,
  output logic             sh_lr,
  input  logic [WIDTH-1:0] sh_y,
  input  logic             sh_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             la_q;
  logic             lr_q;
  logic             c_q;
  logic [CW-1:0]    amt_clamp;

  always_comb begin
    amt_clamp = '0;
    if (32'(amount) > WIDTH)
      amt_clamp = CW'(WIDTH);
    else
      amt_clamp = CW'(amount);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      la_q  <= 1'b0;
      lr_q  <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            work <= a_in;
            cnt  <= amt_clamp;
            la_q <= la_in;
            lr_q <= lr_in;
            c_q  <= 1'b0;
            if (amt_clamp == '0)
              state <= DONE;
            else
              state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= sh_y;
          c_q  <= sh_c;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registers only; start never reaches them.
  assign sh_a  = work;
  assign sh_la = la_q;
  assign sh_lr = lr_q;
  assign y     = work;
  assign c     = c_q;
  assign busy  = (state == SHIFT) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that performs an N-position shift by driving the team's single-step 8-bit shifter one position per clock. It latches an operand and mode on a start pulse and feeds the shifter output back into a working register for the requested number of steps. It then presents the result and the last carry-out with a one-cycle done pulse. The block sits between the game-logic FSMs and the shared shifter datapath, and owns that shifter's inputs.

Parameters:
WIDTH, 8, operand/result width; must match the shifter width.
AMT_W, 4, width of the shift-amount input; amounts above WIDTH are clamped to WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
a_in  input  WIDTH  operand, latched on accepted start.
amount  input  AMT_W  number of single-step shifts, latched on accepted start.
la_in  input  1  arithmetic flag (1 = sign-fill on right shift; ignored for left), latched on start.
lr_in  input  1  direction (1 = right, 0 = left), latched on start.
sh_a  output  WIDTH  to shifter A; equals working register.
sh_la  output  1  to shifter LA; latched la.
sh_lr  output  1  to shifter LR; latched lr.
sh_y  input  WIDTH  from shifter Y (combinational single-step result of sh_a).
sh_c  input  1  from shifter C (bit shifted out).
busy  output  1  high in SHIFT and DONE states.
done  output  1  one-cycle pulse, result valid.
y  output  WIDTH  result; equals working register.
c  output  1  carry register: last bit shifted out; 0 if amount = 0.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE; working reg, count, c, la/lr latches = 0. As a result, y=0, sh_a=0, sh_la=0, sh_lr=0, c=0, busy=0, done=0. Reset has priority over all other inputs, including mid-SHIFT; an aborted operation never produces done.
- States: IDLE, SHIFT, DONE (registered; outputs decoded from state/registers, no combinational path from start to outputs).
- IDLE: on start=1 at edge k:
  - load working reg ← a_in; count ← min(amount, WIDTH); latch la_in, lr_in; c ← 0.
  - Next state is DONE if the clamped count = 0, otherwise SHIFT.
- IDLE with start=0: hold all registers; y/c keep the previous result.
- SHIFT: each edge loads working reg ← sh_y, c ← sh_c, count ← count−1. When count = 1 at that edge, next state is DONE.
- DONE: done=1 for exactly this one cycle; next state is IDLE unconditionally.
- Latency: with start accepted at edge k and clamped amount n, exactly n shift edges occur (k+1..k+n). done is high in the cycle after edge k+n. For n = 0, done is high in the cycle after edge k.
- start while busy (SHIFT or DONE) is ignored, not queued. The earliest next accepted start is at edge k+n+2.
- Input changes on a_in/amount/la_in/lr_in after acceptance have no effect on the operation in progress.
- Shifter semantics driven:
  - Left: Y = A<<1 with bit0=0, C=A[7].
  - Right logical: bit7=0.
  - Right arithmetic: bit7 kept.
  - Right (both): C=A[0].
- Clamp: amount ≥ WIDTH runs exactly WIDTH steps (e.g. 15 → 8 steps).
- y and c hold their final values after DONE until the next accepted start or reset.

Test Plan:
- a_in=0x96, lr=0, amount=3, start at edge k → done in the cycle after edge k+3, y=0xB0, c=0; intermediate sh_a 0x96→0x2C→0x58→0xB0; busy high from after edge k through the DONE cycle.
- a_in=0x96, lr=1, la=1, amount=2 → y=0xE5, c=1. Repeat with la=0 → y=0x25, c=1.
- amount=0, a_in=0x5A → done in the cycle after the accepting edge, y=0x5A, c=0, sh_a never changes.
- Clamp: a_in=0x80, lr=1, la=1, amount=15 → 8 steps, y=0xFF, c=1. Also a_in=0x01, lr=0, amount=12 → y=0x00, c=1; done after edge k+8.
- start held high continuously with a_in changing, amount=2 → only starts sampled in IDLE are accepted (accepts at edges k, k+4, …), and each result matches the operand latched at its accept edge.
- rst=1 during SHIFT (after 1 of 4 steps) → next cycle state IDLE, y=0, c=0, busy=0, no done pulse. A start on the following edge runs normally.
